// File: rtl/stream_demux_4_bit.sv
// Registered 1-to-2 valid/ready demultiplexer: in_sel=1 routes to port A, 0 to port B.
// Each port owns a DEPTH-entry FIFO and a wrap-around delivered-word counter.
module stream_demux_4_bit #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [PW:0]      OCC_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]      OCC_ZERO = (PW + 1)'(0);
    localparam logic [PW:0]      OCC_FULL = (PW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Index 1 is port A, index 0 is port B, matching the in_sel encoding.
    logic [WIDTH-1:0] mem_r    [2][DEPTH];
    logic [PW-1:0]    wr_ptr_r [2];
    logic [PW-1:0]    rd_ptr_r [2];
    logic [PW:0]      occ_r    [2];
    logic [CNT_W-1:0] cnt_r    [2];

    logic [1:0] full_s;
    logic [1:0] empty_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic       in_ready_s;

    // Occupancy flags, input readiness for the selected port, and per-port handshakes.
    always_comb begin
        full_s     = 2'b00;
        empty_s    = 2'b00;
        in_ready_s = 1'b0;
        for (int p = 0; p < 2; p++) begin
            full_s[p]  = (occ_r[p] == OCC_FULL);
            empty_s[p] = (occ_r[p] == OCC_ZERO);
        end
        if (in_sel) begin
            in_ready_s = ~full_s[1];
        end else begin
            in_ready_s = ~full_s[0];
        end
        push_s = {in_valid & in_ready_s & in_sel, in_valid & in_ready_s & ~in_sel};
        pop_s  = {a_ready & ~empty_s[1], b_ready & ~empty_s[0]};
    end

    // FIFO storage, pointers, occupancy and delivered-word counters for both ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_r[p][e] <= '0;
                end
                wr_ptr_r[p] <= '0;
                rd_ptr_r[p] <= '0;
                occ_r[p]    <= '0;
                cnt_r[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push_s[p]) begin
                    mem_r[p][wr_ptr_r[p]] <= in_data;
                    wr_ptr_r[p]           <= wr_ptr_r[p] + PTR_ONE;
                end
                if (pop_s[p]) begin
                    rd_ptr_r[p] <= rd_ptr_r[p] + PTR_ONE;
                    cnt_r[p]    <= cnt_r[p] + CNT_ONE;
                end
                // Simultaneous push and pop leaves occupancy unchanged.
                case ({push_s[p], pop_s[p]})
                    2'b10:   occ_r[p] <= occ_r[p] + OCC_ONE;
                    2'b01:   occ_r[p] <= occ_r[p] - OCC_ONE;
                    default: occ_r[p] <= occ_r[p];
                endcase
            end
        end
    end

    assign in_ready = in_ready_s;
    assign a_valid  = ~empty_s[1];
    assign b_valid  = ~empty_s[0];
    assign a_data   = mem_r[1][rd_ptr_r[1]];
    assign b_data   = mem_r[0][rd_ptr_r[0]];
    assign a_count  = cnt_r[1];
    assign b_count  = cnt_r[0];

endmodule

// File: tb/tb_stream_demux_4_bit.sv
// Scoreboard bench for stream_demux_4_bit: per-port expected-word queues
// updated on accepted handshakes, checked by a negedge monitor.
module tb_stream_demux_4_bit;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = 4'h0;
    logic             in_sel = 1'b0;
    logic             a_valid;
    logic             a_ready = 1'b0;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready = 1'b0;
    logic [WIDTH-1:0] b_data;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    stream_demux_4_bit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of pending words per port plus delivered counts.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [CNT_W-1:0] ca = 8'd0;
    logic [CNT_W-1:0] cb = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the model, then apply the handshakes of the coming edge.
    always @(negedge clk) begin
        check("a_valid", {31'd0, a_valid}, {31'd0, qa.size() > 0});
        check("b_valid", {31'd0, b_valid}, {31'd0, qb.size() > 0});
        if (qa.size() > 0) check("a_data", {28'd0, a_data}, {28'd0, qa[0]});
        if (qb.size() > 0) check("b_data", {28'd0, b_data}, {28'd0, qb[0]});
        check("a_count", {24'd0, a_count}, {24'd0, ca});
        check("b_count", {24'd0, b_count}, {24'd0, cb});
        check("in_ready", {31'd0, in_ready},
              {31'd0, in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH)});
        if (rst) begin
            logic acc;
            acc = in_valid && (in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH));
            if (qa.size() > 0 && a_ready) begin
                void'(qa.pop_front());
                ca = ca + 8'd1;
            end
            if (qb.size() > 0 && b_ready) begin
                void'(qb.pop_front());
                cb = cb + 8'd1;
            end
            if (acc) begin
                if (in_sel) qa.push_back(in_data);
                else        qb.push_back(in_data);
            end
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a word and hold it until accepted; returns just after the accepting edge.
    task automatic push(input logic [WIDTH-1:0] d, input logic s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("push_timeout", {31'd0, n < 50}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Mid-cycle asynchronous reset, checked before any clock edge.
    task automatic do_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        qa.delete();
        qb.delete();
        ca = 8'd0;
        cb = 8'd0;
        #1;
        check("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        check("rst_a_count", {24'd0, a_count}, 32'd0);
        check("rst_b_count", {24'd0, b_count}, 32'd0);
        check("rst_a_data", {28'd0, a_data}, 32'd0);
        check("rst_b_data", {28'd0, b_data}, 32'd0);
        in_sel = 1'b1;
        #1;
        check("rst_ready_sel1", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b0;
        #1;
        check("rst_ready_sel0", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic acc;
        cyc(2);
        rst = 1'b1;
        cyc(1);

        // Reset with both FIFOs holding two words, then first push after reset.
        a_ready = 1'b0;
        b_ready = 1'b0;
        push(4'h1, 1'b1);
        push(4'h2, 1'b1);
        push(4'h3, 1'b0);
        push(4'h4, 1'b0);
        idle();
        check("pre_rst_full", {31'd0, a_valid & b_valid}, 32'd1);
        do_reset();
        push(4'h5, 1'b1);
        idle();
        check("post_rst_a_valid", {31'd0, a_valid}, 32'd1);
        check("post_rst_a_data", {28'd0, a_data}, 32'h5);
        a_ready = 1'b1;
        cyc(2);

        // Routing.
        do_reset();
        a_ready = 1'b1;
        b_ready = 1'b1;
        push(4'h3, 1'b1);
        push(4'hC, 1'b0);
        push(4'h9, 1'b1);
        idle();
        cyc(4);
        check("route_a_count", {24'd0, a_count}, 32'd2);
        check("route_b_count", {24'd0, b_count}, 32'd1);

        // Backpressure on A while B keeps flowing.
        do_reset();
        a_ready = 1'b0;
        b_ready = 1'b0;
        push(4'h1, 1'b1);
        push(4'h2, 1'b1);
        idle();
        in_sel = 1'b1;
        #1;
        check("bp_ready_sel1", {31'd0, in_ready}, 32'd0);
        in_sel = 1'b0;
        #1;
        check("bp_ready_sel0", {31'd0, in_ready}, 32'd1);
        cyc(1);
        push(4'hF, 1'b0);
        idle();
        in_sel  = 1'b1;
        a_ready = 1'b1;
        cyc(1);
        check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        b_ready = 1'b1;
        cyc(3);

        // Concurrent push and pop with one word resident in A.
        do_reset();
        a_ready = 1'b0;
        push(4'hE, 1'b1);
        a_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(4'(i), 1'b1);
            check("conc_a_valid", {31'd0, a_valid}, 32'd1);
        end
        idle();
        cyc(3);
        check("conc_a_count", {24'd0, a_count}, 32'd11);

        // Counter wrap on B.
        do_reset();
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 257; i++) push(4'($urandom), 1'b0);
        idle();
        cyc(3);
        check("wrap_b_count", {24'd0, b_count}, 32'd1);
        check("wrap_a_count", {24'd0, a_count}, 32'd0);

        // Stalled producer switches destination from full A to B.
        do_reset();
        a_ready = 1'b0;
        b_ready = 1'b0;
        push(4'h1, 1'b1);
        push(4'h2, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'h7;
        in_sel   = 1'b1;
        #1;
        check("stall_ready_a", {31'd0, in_ready}, 32'd0);
        cyc(1);
        in_sel = 1'b0;
        #1;
        check("stall_ready_b", {31'd0, in_ready}, 32'd1);
        cyc(1);
        idle();
        check("stall_b_valid", {31'd0, b_valid}, 32'd1);
        check("stall_b_data", {28'd0, b_data}, 32'h7);
        a_ready = 1'b1;
        b_ready = 1'b1;
        cyc(3);
        check("stall_a_count", {24'd0, a_count}, 32'd2);
        check("stall_b_count", {24'd0, b_count}, 32'd1);

        // Random traffic; a held word keeps its data but may change destination.
        do_reset();
        acc = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!in_valid || acc) begin
                in_valid = 1'($urandom);
                in_data  = 4'($urandom);
                in_sel   = 1'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                in_sel = ~in_sel;
            end
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = 1'($urandom);
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        idle();
        a_ready = 1'b1;
        b_ready = 1'b1;
        cyc(4);
        check("final_drained", {31'd0, a_valid | b_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_4_bit.md
Name: stream_demux_4_bit

Overview:
- Registered 1-to-2 demultiplexer for a valid/ready stream, WIDTH bits wide.
- Each accepted input word is routed by `in_sel` to output port A (`in_sel`=1) or port B (`in_sel`=0). This matches the sel polarity of the team's 2-to-1 mux blocks.
- Each output has its own DEPTH-entry FIFO, so a stalled consumer on one port does not block traffic to the other port.
- Sits between a single producer and two consumers. Each output keeps a wrap-around count of delivered words for debug.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, >=2.
- CNT_W, 8, width of the per-output delivered-word counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept the word on the selected port.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination: 1 = port A, 0 = port B; sampled with in_data.
- a_valid  output  1  port A head word available.
- a_ready  input  1  consumer A accepts.
- a_data  output  WIDTH  port A head word.
- b_valid  output  1  port B head word available.
- b_ready  input  1  consumer B accepts.
- b_data  output  WIDTH  port B head word.
- a_count  output  CNT_W  words delivered on A, modulo 2^CNT_W.
- b_count  output  CNT_W  words delivered on B, modulo 2^CNT_W.

Behaviour:
- Reset:
  - rst low clears immediately, without waiting for a clock edge: both FIFOs empty, a_valid=b_valid=0, a_count=b_count=0, a_data=b_data=0.
  - A reset mid-operation discards all buffered words. The first edge after rst rises behaves as the first cycle after power-up.
- Input handshake:
  - in_ready = NOT full(FIFO chosen by current in_sel). It is combinational from in_sel and the FIFO occupancy. It must not depend on in_valid.
  - Push occurs on a rising edge with in_valid=1 and in_ready=1 (while rst is high). At most one word is pushed per cycle.
  - While in_valid=1 and in_ready=0, the producer holds in_data and in_sel. The block must not lose or duplicate a word.
  - A change of in_sel while in_valid=1 and in_ready=0 is legal. in_ready then re-evaluates against the new port.
- Output handshake (independent per port X):
  - x_valid = FIFO X not empty.
  - x_data = oldest entry, driven from registers.
  - x_data is don't-care while x_valid=0.
  - Pop occurs on an edge with x_valid=1 and x_ready=1.
- Latency: a word pushed on edge N is visible on x_valid/x_data after edge N. There is no combinational in->out path and no pass-through when the FIFO is empty.
- Ordering: words leave each port in the order they were accepted for that port. There is no ordering relation between ports.
- Full FIFO: push and pop cannot coincide on a full FIFO, because in_ready=0 there. After a pop, in_ready rises on the next cycle.
- Simultaneous push+pop on a non-empty, non-full FIFO: occupancy is unchanged and head advances correctly.
- Pointers:
  - log2(DEPTH)-bit read/write pointers wrap modulo DEPTH.
  - Occupancy is tracked with a count or an extra pointer bit, so full and empty are distinguishable.
- Counters: x_count increments by 1 on every pop of port X and wraps 2^CNT_W-1 -> 0. It is never affected by pushes.
- x_ready asserted while x_valid=0 has no effect.
- in_valid=0 never changes state, regardless of in_sel.

Test Plan:
- Reset:
  - Drive rst=0 mid-stream with both FIFOs holding 2 words.
  - Required: a_valid=b_valid=0, counts=0 with no clock edge, and in_ready=1 for either sel.
  - After rst=1, push 4'h5 to A -> a_valid=1, a_data=4'h5 one edge later.
- Routing:
  - Push 4'h3 (sel=1), 4'hC (sel=0), 4'h9 (sel=1) with a_ready=b_ready=1.
  - Required: A emits 3 then 9, B emits C, each one cycle after acceptance.
  - a_count=2, b_count=1.
- Backpressure/full:
  - Hold a_ready=0 and push 4'h1, 4'h2 to A.
  - Required: in_ready=0 with sel=1, and in_ready=1 with sel=0. Push 4'hF to B succeeds.
  - Raise a_ready -> A emits 1, 2 in order, and in_ready (sel=1) returns to 1 the cycle after the first pop.
- Concurrent push/pop:
  - A holds 1 word and a_ready=1 while pushing to A every cycle for 10 cycles (data 0..9).
  - Required: a_valid stays 1 throughout, output order is preserved, no loss, and occupancy stays at 1.
- Counter wrap:
  - Deliver 257 words on B with CNT_W=8.
  - Required: b_count=1, and a_count=0 throughout.
- Stall with sel change:
  - A full, in_valid=1, sel=1; the producer then changes sel to 0.
  - Required: in_ready rises in the same cycle and the word lands in B only.
